// File: rtl/vliw_pkg.sv
// vliw_pkg: shared types and constants for the two-slot VLIW pipeline controller.
package vliw_pkg;

    localparam int unsigned REG_IDX_W = 3;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } pipe_state_t;

    // Pipeline register enables and synchronous clears driven by the controller.
    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic id_ex_write;
        logic ex_mem_write;
        logic mem_wb_write;
        logic if_flush;
        logic id_flush;
        logic ex_flush;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_FREEZE = '0;

    localparam pipe_ctrl_t CTRL_FLOW = '{
        pc_write: 1'b1, if_id_write: 1'b1, id_ex_write: 1'b1,
        ex_mem_write: 1'b1, mem_wb_write: 1'b1, default: 1'b0};

    localparam pipe_ctrl_t CTRL_UNDEF = '{
        id_ex_write: 1'b1, id_flush: 1'b1, ex_mem_write: 1'b1,
        ex_flush: 1'b1, mem_wb_write: 1'b1, default: 1'b0};

    localparam pipe_ctrl_t CTRL_REDIRECT = '{
        pc_write: 1'b1, if_id_write: 1'b1, id_ex_write: 1'b1,
        ex_mem_write: 1'b1, mem_wb_write: 1'b1,
        if_flush: 1'b1, id_flush: 1'b1, default: 1'b0};

    localparam pipe_ctrl_t CTRL_LOAD_USE = '{
        id_ex_write: 1'b1, id_flush: 1'b1, ex_mem_write: 1'b1,
        mem_wb_write: 1'b1, default: 1'b0};

    localparam pipe_ctrl_t CTRL_HALT = '{
        ex_mem_write: 1'b1, ex_flush: 1'b1, mem_wb_write: 1'b1, default: 1'b0};

endpackage

// File: rtl/vliw_pipe_ctrl_if.sv
// vliw_pipe_ctrl_if: hazard inputs from the datapath and stall/flush controls back to it.
interface vliw_pipe_ctrl_if
    import vliw_pkg::*;
;
    logic [REG_IDX_W-1:0] id_alu_rn;
    logic [REG_IDX_W-1:0] id_alu_rm;
    logic [REG_IDX_W-1:0] id_mem_rn;
    logic [REG_IDX_W-1:0] id_mem_rd;
    logic                 id_alu_rn_v;
    logic                 id_alu_rm_v;
    logic                 id_mem_rn_v;
    logic                 id_mem_rd_v;
    logic                 p2_memRead;
    logic [REG_IDX_W-1:0] p2_mem_rd;
    logic                 p2_undef;
    logic                 ex_redirect;
    logic                 p3_mem_req;
    logic                 mem_ready;

    logic                 pc_write;
    logic                 if_id_write;
    logic                 id_ex_write;
    logic                 ex_mem_write;
    logic                 mem_wb_write;
    logic                 IF_flush;
    logic                 ID_flush;
    logic                 EX_flush;
    logic                 halted;
    logic                 err_timeout;

    // Datapath side: supplies hazard information, consumes the controls.
    modport master (
        output id_alu_rn, id_alu_rm, id_mem_rn, id_mem_rd,
        output id_alu_rn_v, id_alu_rm_v, id_mem_rn_v, id_mem_rd_v,
        output p2_memRead, p2_mem_rd, p2_undef, ex_redirect, p3_mem_req, mem_ready,
        input  pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
        input  IF_flush, ID_flush, EX_flush, halted, err_timeout
    );

    // Controller side.
    modport slave (
        input  id_alu_rn, id_alu_rm, id_mem_rn, id_mem_rd,
        input  id_alu_rn_v, id_alu_rm_v, id_mem_rn_v, id_mem_rd_v,
        input  p2_memRead, p2_mem_rd, p2_undef, ex_redirect, p3_mem_req, mem_ready,
        output pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
        output IF_flush, ID_flush, EX_flush, halted, err_timeout
    );

endinterface

// File: rtl/vliw_hazard_detect.sv
// vliw_hazard_detect: load-use comparator between the load in ID/EX and the sources read in ID.
module vliw_hazard_detect
    import vliw_pkg::*;
(
    input  logic                 p2_memRead,
    input  logic [REG_IDX_W-1:0] p2_mem_rd,
    input  logic [REG_IDX_W-1:0] id_alu_rn,
    input  logic [REG_IDX_W-1:0] id_alu_rm,
    input  logic [REG_IDX_W-1:0] id_mem_rn,
    input  logic [REG_IDX_W-1:0] id_mem_rd,
    input  logic                 id_alu_rn_v,
    input  logic                 id_alu_rm_v,
    input  logic                 id_mem_rn_v,
    input  logic                 id_mem_rd_v,
    output logic                 load_use
);

    // Any valid source matching the pending load destination needs one bubble.
    always_comb begin
        load_use = p2_memRead &&
                   ((id_alu_rn_v && (id_alu_rn == p2_mem_rd)) ||
                    (id_alu_rm_v && (id_alu_rm == p2_mem_rd)) ||
                    (id_mem_rn_v && (id_mem_rn == p2_mem_rd)) ||
                    (id_mem_rd_v && (id_mem_rd == p2_mem_rd)));
    end

endmodule

// File: rtl/vliw_pipe_ctrl.sv
// vliw_pipe_ctrl: stall/flush sequencer for the ALU+MEM VLIW pipeline.
// Optional VLIW_PIPE_CTRL_PERF_EN adds saturating stall/flush/wait counters.
module vliw_pipe_ctrl
    import vliw_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            reset,
`ifdef VLIW_PIPE_CTRL_PERF_EN
    output logic [31:0]     stall_cycles,
    output logic [31:0]     flush_events,
    output logic [31:0]     wait_cycles,
`endif
    vliw_pipe_ctrl_if.slave bus
);

    localparam logic [15:0] TIMEOUT_CNT = 16'(MEM_TIMEOUT);

    pipe_state_t state;
    logic [15:0] wait_cnt;
    logic        err_q;
    logic        load_use;
    logic        mem_stall;
    logic        flowing;
    pipe_ctrl_t  run_ctrl;
    pipe_ctrl_t  ctrl;

    vliw_hazard_detect u_hazard (
        .p2_memRead  (bus.p2_memRead),
        .p2_mem_rd   (bus.p2_mem_rd),
        .id_alu_rn   (bus.id_alu_rn),
        .id_alu_rm   (bus.id_alu_rm),
        .id_mem_rn   (bus.id_mem_rn),
        .id_mem_rd   (bus.id_mem_rd),
        .id_alu_rn_v (bus.id_alu_rn_v),
        .id_alu_rm_v (bus.id_alu_rm_v),
        .id_mem_rn_v (bus.id_mem_rn_v),
        .id_mem_rd_v (bus.id_mem_rd_v),
        .load_use    (load_use)
    );

    // RUN-mode priority: undefined > memory stall > redirect > load-use > flow.
    always_comb begin
        mem_stall = bus.p3_mem_req && !bus.mem_ready;
        run_ctrl  = CTRL_FLOW;
        if (bus.p2_undef) begin
            run_ctrl = CTRL_UNDEF;
        end else if (mem_stall) begin
            run_ctrl = CTRL_FREEZE;
        end else if (bus.ex_redirect) begin
            run_ctrl = CTRL_REDIRECT;
        end else if (load_use) begin
            run_ctrl = CTRL_LOAD_USE;
        end
    end

    // A wait released by mem_ready behaves as RUN in the same cycle.
    always_comb begin
        flowing = (state == RUN) || ((state == MEM_WAIT) && bus.mem_ready);
        ctrl    = CTRL_FREEZE;
        if (!reset) begin
            if (state == HALT) begin
                ctrl = CTRL_HALT;
            end else if (flowing) begin
                ctrl = run_ctrl;
            end
        end
    end

    assign bus.pc_write     = ctrl.pc_write;
    assign bus.if_id_write  = ctrl.if_id_write;
    assign bus.id_ex_write  = ctrl.id_ex_write;
    assign bus.ex_mem_write = ctrl.ex_mem_write;
    assign bus.mem_wb_write = ctrl.mem_wb_write;
    assign bus.IF_flush     = ctrl.if_flush;
    assign bus.ID_flush     = ctrl.id_flush;
    assign bus.EX_flush     = ctrl.ex_flush;
    assign bus.halted       = (state == HALT) && !reset;
    assign bus.err_timeout  = err_q;

    // Sequencer state, wait counter and sticky timeout flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= RUN;
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (bus.p2_undef) begin
                        state <= HALT;
                    end else if (mem_stall) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= 16'd1;
                    end
                end
                MEM_WAIT: begin
                    // On release the RUN rules apply with mem_ready high, so only undef can divert.
                    if (bus.mem_ready) begin
                        state <= bus.p2_undef ? HALT : RUN;
                    end else if (wait_cnt == TIMEOUT_CNT) begin
                        state <= HALT;
                        err_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

`ifdef VLIW_PIPE_CTRL_PERF_EN
    logic stall_inc;
    logic flush_inc;
    logic wait_inc;

    // Wait cycles are the memory-frozen cycles, including the RUN cycle that enters the wait.
    always_comb begin
        stall_inc = (ctrl == CTRL_LOAD_USE);
        flush_inc = (ctrl == CTRL_REDIRECT);
        wait_inc  = ((state == RUN) && !bus.p2_undef && mem_stall) ||
                    ((state == MEM_WAIT) && !bus.mem_ready);
    end

    // Saturating performance counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_events <= '0;
            wait_cycles  <= '0;
        end else begin
            if (stall_inc && (stall_cycles != '1)) stall_cycles <= stall_cycles + 32'd1;
            if (flush_inc && (flush_events != '1)) flush_events <= flush_events + 32'd1;
            if (wait_inc && (wait_cycles != '1))   wait_cycles  <= wait_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: doc/vliw_pipe_ctrl.md
# vliw_pipe_ctrl

Hazard and sequencing controller for the two-slot (ALU + MEM) VLIW pipeline. It drives the write enables and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC write enable. It resolves load-use hazards, branch/jump redirects, multi-cycle data-memory waits and undefined-instruction halts. It sits beside the datapath in the CPU top level and is the only source of pipeline stall/flush control.

## Interface
- MEM_TIMEOUT, 16: maximum consecutive MEM_WAIT cycles before a timeout halt; legal range 1..65535.
- clk  in  1  pipeline clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- id_alu_rn, id_alu_rm, id_mem_rn, id_mem_rd  in  3 each  source register indices of the pair currently in ID
- id_alu_rn_v, id_alu_rm_v, id_mem_rn_v, id_mem_rd_v  in  1 each  the matching source is actually read (mem_rd valid only for stores)
- p2_memRead  in  1  ID/EX slot holds a load
- p2_mem_rd  in  3  load destination in ID/EX
- p2_undef  in  1  OR of both slots' undefined-instruction flags in ID/EX
- ex_redirect  in  1  taken branch or jump resolved in EX this cycle
- p3_mem_req  in  1  EX/MEM holds a load or store
- mem_ready  in  1  data memory completes the access this cycle
- pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write  out  1 each  register enables
- IF_flush, ID_flush, EX_flush  out  1 each  synchronous clears of IF/ID, ID/EX control bits, EX/MEM
- halted  out  1  controller in HALT
- err_timeout  out  1  sticky, HALT entered by memory timeout

## Operation
- Registered state: FSM {RUN, MEM_WAIT, HALT}, 16-bit wait counter, sticky err_timeout. All outputs are combinational from state and inputs.
- Reset (asserted at any time, including mid-wait): state=RUN, counter=0, err_timeout=0. While reset is high, all enables are 0, all flushes are 0, and halted=0.
- RUN. The first matching condition applies:
  1. p2_undef: go to HALT this edge. In the same cycle: pc_write=if_id_write=0, id_ex_write=1, ID_flush=1, ex_mem_write=1, EX_flush=1, mem_wb_write=1.
  2. p3_mem_req && !mem_ready: go to MEM_WAIT, counter←1. All five enables are 0 and all flushes are 0.
  3. ex_redirect: all enables are 1, IF_flush=1, ID_flush=1, EX_flush=0. Redirect beats a simultaneous load-use hazard.
  4. Load-use: p2_memRead and p2_mem_rd equals any valid ID source. Then pc_write=if_id_write=0, id_ex_write=1, ID_flush=1 (one bubble), and the other enables are 1.
  5. Otherwise all enables are 1 and all flushes are 0.
- MEM_WAIT:
  - Everything is frozen (all enables 0, all flushes 0). ex_redirect, p2_undef and load-use are ignored because they are held by the frozen ID/EX.
  - mem_ready=1: return to RUN and apply the RUN outputs in that same cycle, with mem_ready treated as 1.
  - Otherwise, when counter==MEM_TIMEOUT, go to HALT with err_timeout←1. Else counter←counter+1.
- HALT:
  - pc_write=if_id_write=id_ex_write=0.
  - ex_mem_write=1 with EX_flush=1, and mem_wb_write=1, so older instructions drain and bubbles follow.
  - halted=1. Only reset exits HALT.
- Register 0 carries no special meaning; index compare is full 3-bit.

## Timing
- Load-use costs exactly 1 bubble cycle. A back-to-back load pair in which the second load depends on the first stalls once per dependence.
- Redirect costs 2 squashed slots (IF/ID and ID/EX). There is no extra stall cycle.
- MEM_WAIT lasts N cycles for N cycles of mem_ready=0. The timeout halt fires on the edge following the MEM_TIMEOUT-th wait cycle.
- There is no combinational path from mem_ready to state, other than the documented same-cycle release in MEM_WAIT.

## Configuration
- VLIW_PIPE_CTRL_PERF_EN defined: add 32-bit outputs stall_cycles, flush_events and wait_cycles. Each is cleared by reset and saturates at 0xFFFFFFFF.
  - stall_cycles counts load-use cycles.
  - flush_events counts redirect cycles.
  - wait_cycles counts MEM_WAIT cycles.
- VLIW_PIPE_CTRL_PERF_EN undefined: these ports and their counters are absent. Control behaviour is identical.

## Structure
- Shared package vliw_pkg holds:
  - REG_IDX_W=3
  - the state enum typedef (RUN, MEM_WAIT, HALT)
  - the pipe_ctrl_t struct bundling the five enables and three flushes
- One sub-module, vliw_hazard_detect: a pure combinational load-use comparator (four valid-gated 3-bit compares OR-ed), instantiated once.

## Test plan
- Load-use: p2_memRead=1, p2_mem_rd=3, id_alu_rm=3 valid → one cycle with pc_write=0, if_id_write=0, ID_flush=1; the next cycle all enables are 1.
- Same match but id_alu_rm_v=0 → no stall. A store with id_mem_rd=3 valid → stall.
- Redirect and load-use in the same cycle → IF_flush=1, ID_flush=1, pc_write=1. With PERF_EN, flush_events +1 and stall_cycles unchanged.
- p3_mem_req=1 with mem_ready low for 5 cycles → all enables 0 for exactly 5 cycles. On the mem_ready cycle the enables are 1, the state returns to RUN and err_timeout=0.
- MEM_TIMEOUT=4 with mem_ready held low → halted=1 and err_timeout=1 after the 4th wait cycle. Asserting reset mid-HALT clears both asynchronously.
- p2_undef=1 during RUN → HALT. pc_write stays 0 for 20 cycles, mem_wb_write=1 and EX_flush=1 throughout.
